hex_display_scheduler: RTL
==========================

Name: hex_display_scheduler

Overview:
Time-shares one combinational nibble-to-7-segment decoder across four board HEX displays. It accepts a 16-bit display value from game logic over a valid/ready handshake. It scans the four nibbles through the shared decoder one per cycle and captures each segment pattern into a per-digit register. It drives HEX0..HEX3 with per-digit blank and blink control, for score, turn and winner indication in the connect-4 top level.

Parameters:
BLINK_DIV, 25000000, clock cycles per blink half-period (0.5 s at 50 MHz); legal range >= 2
BLANK_PAT, 7'h7F, segment pattern for a dark digit (active-low segments, all off)

Ports:
clock  input  1  system clock, rising edge
resetn  input  1  asynchronous active-low reset
upd_valid  input  1  new display value offered
upd_ready  output  1  scheduler can accept a value
upd_value  input  16  four nibbles; [3:0] -> HEX0 ... [15:12] -> HEX3
blank_mask  input  4  bit n forces HEXn dark
blink_mask  input  4  bit n makes HEXn blink
dec_nibble  output  4  nibble presented to shared decoder SW input
dec_segs  input  7  shared decoder HEX output (active-low), combinational from dec_nibble
HEX0  output  7  digit 0 segments, active-low
HEX1  output  7  digit 1 segments, active-low
HEX2  output  7  digit 2 segments, active-low
HEX3  output  7  digit 3 segments, active-low

Behaviour:
- Reset (resetn low, async): state IDLE; shadow value = 0; seg_reg0..3 = BLANK_PAT; HEX0..3 = BLANK_PAT; blink counter = 0; blink_phase = 0; dec_nibble = 0; upd_ready = 1 once resetn is high.
- FSM states: IDLE, SCAN0, SCAN1, SCAN2, SCAN3.
- IDLE: upd_ready = 1; dec_nibble = 0. At an edge with upd_valid & upd_ready: latch upd_value into shadow, go to SCAN0.
- SCANk (k = 0..3): upd_ready = 0; dec_nibble = shadow[4k+3:4k]. At the edge ending SCANk, seg_reg k <= dec_segs, then go to SCAN(k+1); SCAN3 goes to IDLE.
- Exactly one handshake is accepted per 5-cycle update. upd_valid during SCANk is ignored and not queued. The producer holds upd_valid until the cycle in which upd_ready is seen high.
- Latency (accept edge = E0):
  - seg_reg k is written at edge E(k+1).
  - HEXk reflects the new value at E(k+2); all digits are new by E5.
  - upd_ready returns high after E4, so the next accept is at E5 at the earliest (back-to-back throughput: 1 update per 5 cycles).
- Blink timer: counter runs 0..BLINK_DIV-1, free-running from reset in every state. On wrap it returns to 0 and blink_phase toggles. Phase 0 = visible, phase 1 = dark.
- Output registers, updated every edge:
  - HEXn <= BLANK_PAT if blank_mask[n];
  - else BLANK_PAT if blink_mask[n] & blink_phase;
  - else seg_reg n.
  - Blank has priority over blink. Mask changes take effect at the next edge, independent of FSM state. Blink does not disturb seg_reg, so a blinking digit keeps its value through scans.
- A digit not yet rescanned keeps its old seg_reg value, so a mid-update display may briefly show a mix of old and new digits.
- Reset asserted mid-scan: partial update is discarded and all outputs return to reset values immediately, without waiting for a clock edge.
- No arithmetic beyond the blink counter, which is sized to ceil(log2(BLINK_DIV)) bits and must not overflow before wrap.

Test Plan:
- Reset release, no update -> HEX0..3 = 7'h7F, upd_ready = 1, dec_nibble = 0.
- Accept 0x1234 at E0 with a standard decoder model -> dec_nibble 4,3,2,1 over the next 4 cycles; HEX0 = 7'h19 at E2, HEX1 = 7'h30 at E3, HEX2 = 7'h24 at E4, HEX3 = 7'h79 at E5; upd_ready low E0..E4.
- upd_valid held high with 0x1234 then 0xAF00 -> second accept exactly at E5; final HEX3 = 7'h08 (A), HEX2 = 7'h0E (F), HEX1 = HEX0 = 7'h40 (0); no value lost or duplicated.
- BLINK_DIV = 4, value 0x0001, blink_mask = 4'b0001 -> HEX0 alternates 7'h79 / 7'h7F every 4 cycles; HEX1..3 steady 7'h40.
- blank_mask = 4'b0001 and blink_mask = 4'b0001 together -> HEX0 constant 7'h7F; clearing blank_mask resumes blinking at the next edge.
- Accept 0x5555, pull resetn low during SCAN2 -> all HEX = 7'h7F in the same cycle, without waiting for an edge; after release upd_ready = 1 and a new 0x0000 update shows 7'h40 on all four digits by E5.

Source files
------------

// File: rtl/hex_display_scheduler.sv
// Time-shares one nibble-to-7-segment decoder across four HEX displays.
// Accepts a 16-bit value, scans its nibbles through the decoder and drives HEX0..3 with blank/blink control.
module hex_display_scheduler #(
    parameter int unsigned BLINK_DIV = 25000000,
    parameter logic [6:0]  BLANK_PAT = 7'h7F
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        upd_valid,
    output logic        upd_ready,
    input  logic [15:0] upd_value,
    input  logic [3:0]  blank_mask,
    input  logic [3:0]  blink_mask,
    output logic [3:0]  dec_nibble,
    input  logic [6:0]  dec_segs,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX3
);

    localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    typedef enum logic [2:0] {IDLE, SCAN0, SCAN1, SCAN2, SCAN3} state_t;

    state_t          state, state_nxt;
    logic [15:0]     shadow;
    logic [3:0][6:0] seg_reg;
    logic [3:0][6:0] hex_q;
    logic [CW-1:0]   blink_cnt;
    logic            blink_phase;
    logic            scan_we;
    logic [1:0]      scan_idx;
    logic            accept;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        upd_ready  = 1'b0;
        dec_nibble = 4'h0;
        scan_we    = 1'b0;
        scan_idx   = 2'd0;
        case (state)
            IDLE: begin
                upd_ready = 1'b1;
                if (upd_valid) state_nxt = SCAN0;
            end
            SCAN0: begin
                dec_nibble = shadow[3:0];
                scan_we    = 1'b1;
                scan_idx   = 2'd0;
                state_nxt  = SCAN1;
            end
            SCAN1: begin
                dec_nibble = shadow[7:4];
                scan_we    = 1'b1;
                scan_idx   = 2'd1;
                state_nxt  = SCAN2;
            end
            SCAN2: begin
                dec_nibble = shadow[11:8];
                scan_we    = 1'b1;
                scan_idx   = 2'd2;
                state_nxt  = SCAN3;
            end
            SCAN3: begin
                dec_nibble = shadow[15:12];
                scan_we    = 1'b1;
                scan_idx   = 2'd3;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept = upd_valid & upd_ready;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)     shadow <= 16'h0000;
        else if (accept) shadow <= upd_value;
    end

    // Decoder output is captured at the edge ending each scan state.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)      seg_reg           <= {4{BLANK_PAT}};
        else if (scan_we) seg_reg[scan_idx] <= dec_segs;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == CW'(BLINK_DIV - 1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt   <= blink_cnt + 1'b1;
        end
    end

    // Blank wins over blink; seg_reg is untouched so blinking digits keep their value.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            hex_q <= {4{BLANK_PAT}};
        end else begin
            for (int n = 0; n < 4; n++) begin
                if (blank_mask[n] | (blink_mask[n] & blink_phase)) hex_q[n] <= BLANK_PAT;
                else                                               hex_q[n] <= seg_reg[n];
            end
        end
    end

    assign HEX0 = hex_q[0];
    assign HEX1 = hex_q[1];
    assign HEX2 = hex_q[2];
    assign HEX3 = hex_q[3];

endmodule
